// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the PC into instruction memory and presents {PC+4, instruction} to ID.
// Latency: a word returned with imem_ready in cycle N appears on IF_ID after posedge N (one cycle).
// Backpressure: stall from ID holds IF_ID and the PC; one word already in flight is parked in hold_buf.
//
// Ports:
//   clk, reset_b                  - clock (posedge) and asynchronous active-low reset
//   imem_req/imem_addr            - fetch request and address (always the current PC)
//   imem_ready/imem_rdata         - fetch completion and returned instruction word
//   stall                         - ID hazard bubble; masks the ID-side jump redirects
//   PCSrcJ/jump_address           - ID j/jal redirect
//   PCSrcJR/jr_address            - ID jr/jalr redirect
//   branch_taken/branch_address   - EX resolved-taken branch redirect
//   exception                     - ID exception, redirects to EXC_VECTOR
//   IF_ID/IF_ID_valid             - pipeline register to ID: [63:32] PC+4, [31:0] instruction; zero = bubble
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrcJ,
    input  logic [31:0] jump_address,
    input  logic        PCSrcJR,
    input  logic [31:0] jr_address,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    input  logic        exception,
    output logic [63:0] IF_ID,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    if_id_t      hold_buf_q, hold_buf_d;
    if_id_t      if_id_q, if_id_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [31:0] pc_plus4;
    logic        redir_j;
    logic        redir_jr;
    logic        redirect;
    logic [31:0] redirect_target;
    if_id_t      fetched;

    // Bit 31 marks kernel space and must survive sequential execution,
    // so only the low 31 bits advance (and wrap).
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    assign fetched  = '{pc_plus4: pc_plus4, instr: imem_rdata};

    // ID-side jumps belong to the instruction ID is stalling on; they are
    // re-presented once the stall clears. EX branches and exceptions are final.
    assign redir_j  = PCSrcJ & ~stall;
    assign redir_jr = PCSrcJR & ~stall;
    assign redirect = exception | branch_taken | redir_jr | redir_j;

    always_comb begin
        redirect_target = jump_address;
        if (exception) begin
            redirect_target = EXC_VECTOR;
        end else if (branch_taken) begin
            redirect_target = branch_address;
        end else if (redir_jr) begin
            redirect_target = jr_address;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        hold_buf_d    = hold_buf_q;
        if_id_d       = if_id_q;
        if_id_valid_d = if_id_valid_q;

        if (redirect) begin
            // Everything younger than the redirecting instruction is squashed,
            // regardless of stall.
            if_id_d       = '0;
            if_id_valid_d = 1'b0;
            hold_buf_d    = '0;
        end

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d    = redirect_target;
                    end else begin
                        // The request at the old PC must run to completion
                        // before the address may change; its data is dropped.
                        pending_pc_d = redirect_target;
                        state_d      = DISCARD;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (!stall) begin
                        if_id_d       = fetched;
                        if_id_valid_d = 1'b1;
                    end else begin
                        hold_buf_d = fetched;
                        state_d    = HOLD;
                    end
                end else if (!stall) begin
                    if_id_d       = '0;
                    if_id_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    if_id_d       = hold_buf_q;
                    if_id_valid_d = 1'b1;
                    state_d       = FETCH;
                end
            end

            DISCARD: begin
                if_id_d       = '0;
                if_id_valid_d = 1'b0;
                if (redirect) begin
                    pending_pc_d = redirect_target;
                end
                if (imem_ready) begin
                    // A redirect arriving with the completion is the newest
                    // target, so it wins over the stored one.
                    pc_d    = redirect ? redirect_target : pending_pc_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            pending_pc_q  <= '0;
            hold_buf_q    <= '0;
            if_id_q       <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            hold_buf_q    <= hold_buf_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // HOLD already owns one fetched word, so no further request is issued.
    assign imem_req    = (state_q != HOLD);
    assign imem_addr   = pc_q;
    assign IF_ID       = if_id_q;
    assign IF_ID_valid = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run, checked by a program-order scoreboard.
// Latency: expected stream is consumed one entry per cycle in which ID accepts a valid IF_ID.
// Backpressure: stall is driven by the bench; stalled IF_ID must match the scoreboard head without popping.
module tb_if_stage;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrcJ;
    logic [31:0] jump_address;
    logic        PCSrcJR;
    logic [31:0] jr_address;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        exception;
    logic [63:0] IF_ID;
    logic        IF_ID_valid;

    if_stage #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .PCSrcJ         (PCSrcJ),
        .jump_address   (jump_address),
        .PCSrcJR        (PCSrcJR),
        .jr_address     (jr_address),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .exception      (exception),
        .IF_ID          (IF_ID),
        .IF_ID_valid    (IF_ID_valid)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          consumed    = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    bit          mon_en      = 1'b0;

    // Memory contents: a bijective scramble of the address, so every
    // location holds a distinct word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Sequential successor: kernel bit preserved, remaining bits wrap.
    function automatic logic [31:0] plus4(input logic [31:0] a);
        return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom & 32'hFFFF_FFFC;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return 32'h0000_1000 + (r & 32'h0000_0FFC);
            2:       return 32'h7FFF_FFF0 + (r & 32'h0000_000C);
            default: return 32'hFFFF_FFF0 + (r & 32'h0000_000C);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected instruction stream in program order from exp_pc onward.
    task automatic sb_refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({plus4(exp_pc), word_at(exp_pc)});
            exp_pc = plus4(exp_pc);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        exp_pc = pc;
        sb_refill();
    endtask

    // Called at posedge+1: applies one cycle of inputs, updates the
    // reference stream for any effective redirect, then advances a cycle.
    task automatic drive(input bit rdy, input bit stl, input bit j, input bit jr,
                         input bit br, input bit exc, input logic [31:0] ja,
                         input logic [31:0] jra, input logic [31:0] ba);
        imem_ready     = rdy & imem_req;
        imem_rdata     = (rdy & imem_req) ? word_at(imem_addr) : 32'hDEAD_BEEF;
        stall          = stl;
        PCSrcJ         = j;
        PCSrcJR        = jr;
        branch_taken   = br;
        exception      = exc;
        jump_address   = ja;
        jr_address     = jra;
        branch_address = ba;
        if (exc)             sb_restart(EXC_VECTOR);
        else if (br)         sb_restart(ba);
        else if (!stl && jr) sb_restart(jra);
        else if (!stl && j)  sb_restart(ja);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit rdy, input bit stl);
        drive(rdy, stl, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: ID accepts IF_ID when it is valid, not stalled and not squashed.
    always @(negedge clk) begin : monitor
        logic redir;
        if (mon_en && reset_b) begin
            redir = exception | branch_taken | (~stall & (PCSrcJ | PCSrcJR));
            if (!IF_ID_valid) begin
                check("bubble_is_zero", IF_ID, 64'h0);
            end else if (!redir) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL if_id_stream: got %h, expected nothing queued", IF_ID);
                end else begin
                    check("if_id_stream", IF_ID, exp_q[0]);
                    if (!stall) begin
                        void'(exp_q.pop_front());
                        consumed++;
                        sb_refill();
                    end
                end
            end
        end
    end

    initial begin
        reset_b        = 1'b0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        PCSrcJ         = 1'b0;
        PCSrcJR        = 1'b0;
        branch_taken   = 1'b0;
        exception      = 1'b0;
        jump_address   = 32'h0;
        jr_address     = 32'h0;
        branch_address = 32'h0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_if_id", IF_ID, 64'h0);
        check("reset_valid", 64'(IF_ID_valid), 64'd0);
        check("reset_req", 64'(imem_req), 64'd1);
        check("reset_addr", 64'(imem_addr), 64'(RESET_PC));
        reset_b = 1'b1;
        sb_restart(RESET_PC);
        mon_en = 1'b1;

        // Zero-wait sequential fetch
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            check("seq_if_id", IF_ID, {RESET_PC + 32'(4 * (i + 1)), word_at(RESET_PC + 32'(4 * i))});
        end

        // Jump redirect squashes the concurrent fetch; masked under stall
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0);
        check("jump_if_id_bubble", IF_ID, 64'h0);
        check("jump_valid", 64'(IF_ID_valid), 64'd0);
        check("jump_addr", 64'(imem_addr), 64'h0000_0040);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0);
        check("masked_jump_addr", 64'(imem_addr), 64'h0000_0044);
        check("masked_jump_hold_req", 64'(imem_req), 64'd0);
        step(1'b0, 1'b0);
        check("masked_jump_release", IF_ID, {32'h0000_0044, word_at(32'h0000_0040)});

        // Branch while a fetch is outstanding: old word dropped
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0100);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0200);
        check("discard_req", 64'(imem_req), 64'd1);
        check("discard_addr_held", 64'(imem_addr), 64'h0000_0100);
        step(1'b0, 1'b0);
        check("discard_addr_wait", 64'(imem_addr), 64'h0000_0100);
        step(1'b1, 1'b0);
        check("discard_new_addr", 64'(imem_addr), 64'h0000_0200);
        check("discard_if_id_bubble", IF_ID, 64'h0);

        // Stall with a word in flight: parked, no request, released intact
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("hold_req_1", 64'(imem_req), 64'd0);
        step(1'b0, 1'b1);
        check("hold_req_2", 64'(imem_req), 64'd0);
        step(1'b0, 1'b1);
        check("hold_req_3", 64'(imem_req), 64'd0);
        step(1'b0, 1'b0);
        check("hold_release_if_id", IF_ID, {32'h0000_0208, word_at(32'h0000_0204)});
        check("hold_release_valid", 64'(IF_ID_valid), 64'd1);
        check("hold_release_addr", 64'(imem_addr), 64'h0000_0208);

        // Exception beats branch; kernel-bit wrap
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0000_0300);
        check("exc_priority_addr", 64'(imem_addr), 64'(EXC_VECTOR));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        step(1'b1, 1'b0);
        check("wrap_pc_plus4", 64'(IF_ID[63:32]), 64'h8000_0000);
        check("wrap_next_addr", 64'(imem_addr), 64'h8000_0000);

        // Asynchronous reset in the middle of DISCARD
        step(1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0500);
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        reset_b      = 1'b0;
        #1;
        check("async_rst_if_id", IF_ID, 64'h0);
        check("async_rst_valid", 64'(IF_ID_valid), 64'd0);
        check("async_rst_addr", 64'(imem_addr), 64'(RESET_PC));
        check("async_rst_req", 64'(imem_req), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        sb_restart(RESET_PC);
        step(1'b1, 1'b0);
        check("post_rst_first", IF_ID, {RESET_PC + 32'd4, word_at(RESET_PC)});

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t0, t1, t2;
            t0 = rand_target();
            t1 = rand_target();
            t2 = rand_target();
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 2,
                  t0, t1, t2);
        end
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b0);
        end
        check("stream_progress", 64'(consumed >= 200), 64'd1);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
